// File: rtl/lease_loader_pkg.sv
// Shared encodings for the lease table loader: command ops, table regions and FSM states.
package lease_loader_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;

  localparam logic [1:0] REG_ADDR   = 2'b00;
  localparam logic [1:0] REG_LEASE0 = 2'b01;
  localparam logic [1:0] REG_LEASE1 = 2'b10;
  localparam logic [1:0] REG_PROB   = 2'b11;

  // ST_CHECK is only reachable when the trailer checksum is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_FINISH = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

endpackage

// File: rtl/lease_loader_checksum.sv
// Wrap-around 32-bit sum of loaded words, compared against the trailer word.
// Instantiated by lease_table_loader only when LEASE_LOADER_CHECKSUM_EN is defined.
module lease_loader_checksum (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear,
  input  logic        accumulate,
  input  logic [31:0] word,
  output logic        sum_match
);

  logic [31:0] sum_r;

  // Running sum: restarted on every accepted command, bumped on every loaded word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sum_r <= 32'd0;
    end else if (clear) begin
      sum_r <= 32'd0;
    end else if (accumulate) begin
      sum_r <= sum_r + word;
    end else begin
      sum_r <= sum_r;
    end
  end

  // Trailer comparison is sampled by the loader in the same cycle it accepts the trailer.
  assign sum_match = (word == sum_r);

endmodule

// File: rtl/lease_table_loader.sv
// Sequencer that fills the lease lookup table from a host word stream (LOAD) or sweeps it clean (CLEAR).
// Optional trailer checksum over loaded words: define LEASE_LOADER_CHECKSUM_EN.
module lease_table_loader
  import lease_loader_pkg::*;
#(
  parameter int N_ENTRIES = 128
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [1:0]                       cmd_op_i,
  input  logic [$clog2(N_ENTRIES):0]       cmd_count_i,
  input  logic                             data_valid_i,
  output logic                             data_ready_o,
  input  logic [31:0]                      data_i,
  output logic [$clog2(N_ENTRIES)+1:0]     table_addr_o,
  output logic                             table_wren_o,
  output logic                             table_rmen_o,
  output logic [31:0]                      table_data_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int BW_ENTRIES    = $clog2(N_ENTRIES);
  localparam int BW_ADDR_SPACE = BW_ENTRIES + 2;

  localparam logic [BW_ENTRIES:0]   MAX_COUNT  = (BW_ENTRIES+1)'(N_ENTRIES);
  localparam logic [BW_ENTRIES:0]   ZERO_COUNT = {(BW_ENTRIES+1){1'b0}};
  localparam logic [BW_ENTRIES-1:0] IDX_ZERO   = {BW_ENTRIES{1'b0}};
  localparam logic [BW_ENTRIES-1:0] IDX_ONE    = BW_ENTRIES'(1);
  localparam logic [BW_ENTRIES-1:0] IDX_MAX    = BW_ENTRIES'(N_ENTRIES - 1);

  state_t                  state_r;
  logic [1:0]              region_r;
  logic [BW_ENTRIES-1:0]   index_r;
  logic [BW_ENTRIES-1:0]   last_idx_r;
  logic                    err_flag_r;

  logic                    cmd_fire_s;
  logic                    data_fire_s;
  logic                    count_ok_s;
  logic [BW_ENTRIES-1:0]   idx_last_s;

  assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;
  assign data_fire_s = data_valid_i & data_ready_o;
  assign count_ok_s  = (cmd_count_i != ZERO_COUNT) && (cmd_count_i <= MAX_COUNT);
  // count == N_ENTRIES has zero low bits, so the subtraction wraps to N_ENTRIES-1 as intended.
  assign idx_last_s  = cmd_count_i[BW_ENTRIES-1:0] - IDX_ONE;

`ifdef LEASE_LOADER_CHECKSUM_EN
  logic sum_match_s;

  lease_loader_checksum u_checksum (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear      (cmd_fire_s),
    .accumulate (data_fire_s && (state_r == ST_LOAD)),
    .word       (data_i),
    .sum_match  (sum_match_s)
  );
`endif

  // Command/stream sequencer; every output is registered alongside the state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      region_r     <= 2'b00;
      index_r      <= IDX_ZERO;
      last_idx_r   <= IDX_ZERO;
      err_flag_r   <= 1'b0;
      cmd_ready_o  <= 1'b1;
      data_ready_o <= 1'b0;
      table_addr_o <= {BW_ADDR_SPACE{1'b0}};
      table_wren_o <= 1'b0;
      table_rmen_o <= 1'b0;
      table_data_o <= 32'd0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      table_wren_o <= 1'b0;
      table_rmen_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            region_r    <= REG_ADDR;
            index_r     <= IDX_ZERO;
            last_idx_r  <= idx_last_s;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if ((cmd_op_i == OP_LOAD) && count_ok_s) begin
              state_r      <= ST_LOAD;
              data_ready_o <= 1'b1;
              err_flag_r   <= 1'b0;
            end else if (cmd_op_i == OP_CLEAR) begin
              // First remove strobe leaves with the acceptance edge so the sweep has no gap.
              state_r      <= ST_CLEAR;
              table_rmen_o <= 1'b1;
              table_addr_o <= {BW_ADDR_SPACE{1'b0}};
              err_flag_r   <= 1'b0;
            end else begin
              state_r    <= ST_FINISH;
              err_flag_r <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          if (data_fire_s) begin
            table_wren_o <= 1'b1;
            table_addr_o <= {region_r, index_r};
            table_data_o <= data_i;
            if (index_r == last_idx_r) begin
              index_r  <= IDX_ZERO;
              region_r <= region_r + 2'd1;
              if (region_r == REG_PROB) begin
`ifdef LEASE_LOADER_CHECKSUM_EN
                state_r <= ST_CHECK;
`else
                state_r      <= ST_FINISH;
                data_ready_o <= 1'b0;
`endif
              end else begin
                state_r <= ST_LOAD;
              end
            end else begin
              index_r <= index_r + IDX_ONE;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end

        ST_CLEAR: begin
          if (index_r == IDX_MAX) begin
            state_r <= ST_FINISH;
          end else begin
            index_r      <= index_r + IDX_ONE;
            table_rmen_o <= 1'b1;
            table_addr_o <= {REG_ADDR, index_r + IDX_ONE};
          end
        end

`ifdef LEASE_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // Trailer word is consumed without touching the table.
          if (data_fire_s) begin
            state_r      <= ST_FINISH;
            data_ready_o <= 1'b0;
            err_flag_r   <= ~sum_match_s;
          end else begin
            state_r <= ST_CHECK;
          end
        end
`endif

        ST_FINISH: begin
          state_r     <= ST_IDLE;
          done_o      <= 1'b1;
          err_o       <= err_flag_r;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end

        default: begin
          state_r      <= ST_IDLE;
          cmd_ready_o  <= 1'b1;
          data_ready_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
